paraleloserie: RTL and testbench
================================

Name: paraleloserie

Overview:
- Parallel-to-serial transmitter: the transmit-side counterpart of the serieparalelo deserializer.
- Accepts 8-bit bytes through a valid/ready handshake and serializes them MSB-first, one bit per clk32f cycle.
- Fills every byte slot with no data using the COM symbol, which gives the far-end serieparalelo its alignment pattern.
- Sits between the byte-wide lane logic and the serial link, in the clk32f domain only.

Parameters:
- COM, 8'hBC: idle/alignment symbol; loaded at reset and sent whenever no data byte is available.
- SYNC_COUNT, 4: number of COM bytes sent after reset before data is accepted. Range 1..15.

Ports:
- clk32f  input  1  serial bit clock; single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  8  parallel data byte.
- valid  input  1  in holds a byte to send.
- ready  output  1  block accepts in on this edge when valid=1.
- out  output  1  serial bit stream, MSB first.
- byte_start  output  1  high during the cycle out carries bit 7 of a byte.
- active  output  1  sync phase complete; data is being accepted.

Behaviour:
- Internal state:
  - shift_reg[7:0]
  - bit_cnt[2:0]
  - sync_cnt[3:0]
  - hold_reg[7:0] with hold_full
  - state in {SYNC, ACTIVE}
- Reset (reset=0, acts immediately, no clock needed):
  - shift_reg=COM, bit_cnt=0, sync_cnt=0, hold_full=0, hold_reg=0, state=SYNC.
  - Outputs: out=COM[7]=1, byte_start=1, ready=0, active=0.
- Output decode:
  - out = shift_reg[7] (combinational from the register).
  - byte_start = (bit_cnt==0).
  - active = (state==ACTIVE).
  - ready = active && !hold_full.
- Timing reference: cycle 0 is the cycle after reset deasserts; edge k ends cycle k. Byte n occupies cycles 8n..8n+7.
- Every edge with bit_cnt!=7: shift_reg shifts left by 1 (LSB filled with 0), bit_cnt++.
- Load edge (bit_cnt==7): bit_cnt wraps to 0, and shift_reg loads the next byte:
  - SYNC: load COM and increment sync_cnt. When the incremented value equals SYNC_COUNT, state becomes ACTIVE on the same edge.
  - ACTIVE with hold_full=1: load hold_reg and clear hold_full.
  - ACTIVE with hold_full=0: load COM (idle fill).
- Handshake:
  - Transfer occurs when valid && ready at a rising edge: hold_reg<=in, hold_full<=1.
  - There is no bypass path: a byte accepted on a load edge with hold empty goes to the holding register, and COM is still sent in that slot.
  - When a load empties hold_full, ready is high in the following cycle.
  - Capture and load on the same edge cannot collide, because ready=0 whenever hold_full=1.
  - valid may deassert at any time with no effect. in is sampled only on a transfer edge.
- Latency and throughput:
  - A byte accepted in cycle c appears on out starting at the first byte boundary after c.
  - Continuous valid gives back-to-back data with no COM gaps.
- Data value equal to COM is transmitted unchanged; there is no escaping or K-flag.
- Reset mid-byte or mid-stream: the partial byte and any held byte are discarded, and the block restarts from the SYNC phase with the full SYNC_COUNT.
- No other states exist; there are no error or overflow conditions.

Test Plan:
1. Reset check: reset=0 held, clock toggling → out=1, byte_start=1, ready=0, active=0. Release, valid=0 → bytes 0..SYNC_COUNT are all 8'hBC; active rises in cycle 32; idle COM continues thereafter.
2. Held valid from reset, in=8'hA5, SYNC_COUNT=4 → ready first high in cycle 32, capture at edge 32. Cycles 32–39 carry COM; cycles 40–47 carry out=1,0,1,0,0,1,0,1; byte_start=1 in cycles 0,8,…,40.
3. Back-to-back stream 8'h01, 8'h80, 8'hFF, 8'h00 with valid always high → four consecutive data bytes with no COM between them; ready pulses low from capture until each load edge.
4. Single byte 8'h3C, then valid=0 → 8'h3C sent once, followed by COM forever; hold_full does not re-assert.
5. Assert reset at cycle 44 (mid data byte) and release two cycles later → out=1 immediately, ready=0, active=0. SYNC_COUNT COM bytes are sent again before ready returns; the interrupted byte is never resent.
6. Data byte 8'hBC sent in ACTIVE → serialized verbatim; byte timing and ready behaviour identical to any other value.

Source files
------------

// File: rtl/paraleloserie.sv
// Parallel-to-serial transmitter: serializes bytes MSB-first, one bit per clk32f cycle,
// and fills every empty byte slot with the COM alignment symbol.
module paraleloserie #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [3:0] SYNC_COUNT = 4'd4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       byte_start,
    output logic       active
);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] hold_q;
    logic [7:0] hold_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic [3:0] sync_cnt_q;
    logic [3:0] sync_cnt_d;
    logic       hold_full_q;
    logic       hold_full_d;

    logic       load_s;
    logic       sync_done_s;
    logic       transfer_s;
    logic       ready_s;
    logic       active_s;
    logic       out_s;
    logic       byte_start_s;

    assign load_s      = (bit_cnt_q == 3'd7);
    assign sync_done_s = ((sync_cnt_q + 4'd1) == SYNC_COUNT);
    assign transfer_s  = valid && ready_s;

    // State register
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SYNC on the load edge that completes the last COM byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (load_s && sync_done_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_SYNC;
        endcase
    end

    // Output decode, all taken straight from registered state
    always_comb begin
        active_s     = (state_q == ST_ACTIVE);
        ready_s      = active_s && !hold_full_q;
        out_s        = shift_q[7];
        byte_start_s = (bit_cnt_q == 3'd0);
    end

    // Datapath next values: shift, byte reload and holding-register capture
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load_s) begin
            bit_cnt_d = 3'd0;
            case (state_q)
                ST_SYNC: begin
                    shift_d    = COM;
                    sync_cnt_d = sync_cnt_q + 4'd1;
                end
                ST_ACTIVE: begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d = COM;
                    end
                end
                default: shift_d = COM;
            endcase
        end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        // ready is low while hold is full, so capture never meets a reload of hold
        if (transfer_s) begin
            hold_d      = in;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            shift_q     <= COM;
            bit_cnt_q   <= 3'd0;
            sync_cnt_q  <= 4'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign ready      = ready_s;
    assign out        = out_s;
    assign byte_start = byte_start_s;
    assign active     = active_s;

endmodule

// File: tb/tb_paraleloserie.sv
// Self-checking bench for paraleloserie: directed phases plus random traffic,
// compared every cycle against a byte-slot/queue reference model.
module tb_paraleloserie;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         SYNC = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       out;
    logic       byte_start;
    logic       active;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index since reset, current slot byte, bit position, pending bytes
    int         m_t;
    int         m_pos;
    logic [7:0] m_cur;
    logic [7:0] m_pend[$];

    paraleloserie #(.COM(COM), .SYNC_COUNT(4'(SYNC))) dut (
        .clk32f    (clk),
        .reset     (rst_n),
        .in        (din),
        .valid     (valid),
        .ready     (ready),
        .out       (out),
        .byte_start(byte_start),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    function automatic logic m_active();
        return (m_t >= 8 * SYNC);
    endfunction

    function automatic logic m_ready();
        return m_active() && (m_pend.size() == 0);
    endfunction

    task automatic model_reset();
        m_t   = 0;
        m_pos = 0;
        m_cur = COM;
        m_pend.delete();
    endtask

    // Advance the model across one rising edge with the given inputs
    task automatic model_edge(input logic v, input logic [7:0] d);
        logic xfer;
        int   n;
        xfer = v && m_ready();
        m_pos++;
        if (m_pos == 8) begin
            m_pos = 0;
            n = (m_t + 1) / 8;
            if (n <= SYNC) m_cur = COM;
            else if (m_pend.size() != 0) m_cur = m_pend.pop_front();
            else m_cur = COM;
        end
        if (xfer) m_pend.push_back(d);
        m_t++;
    endtask

    // Check the current cycle, drive inputs for the next edge, advance one cycle
    task automatic cycle(input logic v, input logic [7:0] d);
        chk("out", {7'd0, out}, {7'd0, m_cur[3'(7 - m_pos)]});
        chk("byte_start", {7'd0, byte_start}, {7'd0, (m_pos == 0)});
        chk("active", {7'd0, active}, {7'd0, m_active()});
        chk("ready", {7'd0, ready}, {7'd0, m_ready()});
        valid = v;
        din   = d;
        model_edge(v, d);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out", {7'd0, out}, 8'd1);
        chk("rst_byte_start", {7'd0, byte_start}, 8'd1);
        chk("rst_ready", {7'd0, ready}, 8'd0);
        chk("rst_active", {7'd0, active}, 8'd0);
    endtask

    task automatic do_reset(input int hold, input logic v, input logic [7:0] d);
        rst_n = 1'b0;
        valid = v;
        din   = d;
        #1;
        check_reset_outputs();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] d);
        logic done;
        logic r;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            r = m_ready();
            cycle(1'b1, d);
            if (r) done = 1'b1;
        end
        chk("send_timeout", {7'd0, done}, 8'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        din   = 8'd0;
        model_reset();
        @(negedge clk);

        // Reset and idle COM through sync and beyond
        do_reset(4, 1'b0, 8'd0);
        for (int i = 0; i < 56; i++) begin
            if (m_t == 31) chk("t1_active31", {7'd0, active}, 8'd0);
            if (m_t == 32) chk("t1_active32", {7'd0, active}, 8'd1);
            cycle(1'b0, 8'd0);
        end

        // Valid held from reset with A5
        @(negedge clk);
        do_reset(2, 1'b1, 8'hA5);
        for (int i = 0; i < 48; i++) begin
            if (m_t == 31) chk("t2_ready31", {7'd0, ready}, 8'd0);
            if (m_t == 32) chk("t2_ready32", {7'd0, ready}, 8'd1);
            if (m_t == 40) chk("t2_bit7", {7'd0, out}, 8'd1);
            if (m_t == 41) chk("t2_bit6", {7'd0, out}, 8'd0);
            cycle(1'b1, 8'hA5);
        end

        // Back-to-back stream, then single byte, then COM-valued data
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h3C);
        for (int i = 0; i < 32; i++) cycle(1'b0, 8'h3C);
        send_byte(8'hBC);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);

        // Random traffic
        for (int i = 0; i < 300; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom));

        // Reset in the middle of a data byte, then random traffic again
        @(negedge clk);
        do_reset(1, 1'b0, 8'd0);
        while (m_t < 44) cycle(1'b1, 8'($urandom));
        do_reset(2, 1'b0, 8'd0);
        for (int i = 0; i < 80; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
